// File: rtl/seq_mult_unit_if.sv
// Handshake and data bundle between an operand source and the sequential multiplier.
interface seq_mult_unit_if #(
    parameter int unsigned WIDTH = 8
);
    logic                           start;
    logic                           signed_mode;
    logic [WIDTH-1:0]               a_in;
    logic [WIDTH-1:0]               b_in;
    logic                           ready;
    logic                           done;
    logic [2*WIDTH-1:0]             p_out;
    logic [$clog2(WIDTH+1)-1:0]     iter_count;

    modport master (
        output start, signed_mode, a_in, b_in,
        input  ready, done, p_out, iter_count
    );

    modport slave (
        input  start, signed_mode, a_in, b_in,
        output ready, done, p_out, iter_count
    );
endinterface

// File: rtl/seq_mult_unit.sv
// Shift-add sequential multiplier with signed/unsigned mode and early exit once the
// remaining multiplier bits are all zero. One operation in flight at a time.
module seq_mult_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          clr,
    seq_mult_unit_if.slave bus
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [PW-1:0]     a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [PW-1:0]     p_q, p_d;
    logic              neg_q, neg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [PW-1:0]     p_out_q, p_out_d;
    logic [CW-1:0]     iter_q, iter_d;

    logic [WIDTH-1:0]  a_mag, b_mag;

    // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
    always_comb begin
        a_mag = bus.a_in;
        b_mag = bus.b_in;
        if (bus.signed_mode && bus.a_in[WIDTH-1]) a_mag = -bus.a_in;
        if (bus.signed_mode && bus.b_in[WIDTH-1]) b_mag = -bus.b_in;
    end

    // State and datapath registers; clr wins over everything, including an op in flight.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            p_out_q <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            p_out_q <= p_out_d;
            iter_q  <= iter_d;
        end
    end

    // Next-state and datapath update for IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        p_out_d = p_out_q;
        iter_d  = iter_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    a_d     = {{WIDTH{1'b0}}, a_mag};
                    b_d     = b_mag;
                    p_d     = '0;
                    cnt_d   = '0;
                    neg_d   = bus.signed_mode & (bus.a_in[WIDTH-1] ^ bus.b_in[WIDTH-1]);
                    state_d = StRun;
                end
            end
            StRun: begin
                if (b_q == '0) begin
                    // Result published on entry to DONE so p_out is valid while done is high.
                    p_out_d = neg_q ? -p_q : p_q;
                    iter_d  = cnt_q;
                    state_d = StDone;
                end else begin
                    p_d   = p_q + (b_q[0] ? a_q : '0);
                    a_d   = {a_q[PW-2:0], 1'b0};
                    b_d   = {1'b0, b_q[WIDTH-1:1]};
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded straight from registered state.
    always_comb begin
        bus.ready      = (state_q == StIdle);
        bus.done       = (state_q == StDone);
        bus.p_out      = p_out_q;
        bus.iter_count = iter_q;
    end
endmodule

// File: tb/tb_seq_mult_unit.sv
// Randomised and directed checks of seq_mult_unit against an arithmetic reference model.
module tb_seq_mult_unit;
    localparam int unsigned W = 8;

    logic clk;
    logic clr;
    int   n_cmp;
    int   n_err;

    seq_mult_unit_if #(.WIDTH(W)) bus ();

    seq_mult_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected product by plain integer multiplication, truncated to 2*W bits.
    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input bit sm);
        longint av, bv, pr;
        av = sm ? longint'($signed(a)) : longint'(a);
        bv = sm ? longint'($signed(b)) : longint'(b);
        pr = av * bv;
        return pr[2*W-1:0];
    endfunction

    // Number of significant bits in |b|.
    function automatic int ref_iter(input logic [W-1:0] b, input bit sm);
        longint bv;
        int     k;
        bv = sm ? longint'($signed(b)) : longint'(b);
        if (bv < 0) bv = -bv;
        k = 0;
        while (bv != 0) begin
            k++;
            bv = bv >>> 1;
        end
        return k;
    endfunction

    // One full transaction; optionally pokes start with other operands while busy.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit sm, input bit poke);
        int cyc;
        int k;
        k = ref_iter(b, sm);
        @(negedge clk);
        check({tag, ".ready"}, 64'(bus.ready), 64'd1);
        bus.start       = 1'b1;
        bus.a_in        = a;
        bus.b_in        = b;
        bus.signed_mode = sm;
        @(posedge clk);
        #1;
        bus.start       = 1'b0;
        bus.a_in        = W'($urandom);
        bus.b_in        = W'($urandom);
        bus.signed_mode = 1'($urandom);
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (poke && cyc == 1) begin
                check({tag, ".busy"}, 64'(bus.ready), 64'd0);
                bus.start = 1'b1;
                bus.a_in  = ~a;
                bus.b_in  = ~b;
            end else if (poke && cyc == 2) begin
                bus.start = 1'b0;
            end
            if (bus.done) break;
            if (cyc > W + 6) begin
                check({tag, ".timeout"}, 64'(cyc), 64'(k + 2));
                return;
            end
        end
        bus.start = 1'b0;
        check({tag, ".p"}, 64'(bus.p_out), 64'(ref_prod(a, b, sm)));
        check({tag, ".iter"}, 64'(bus.iter_count), 64'(k));
        check({tag, ".lat"}, 64'(cyc), 64'(k + 2));
        @(negedge clk);
        check({tag, ".single"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int cyc;
        int pulses;
        int gap;
        n_cmp           = 0;
        n_err           = 0;
        clr             = 1'b1;
        bus.start       = 1'b0;
        bus.signed_mode = 1'b0;
        bus.a_in        = '0;
        bus.b_in        = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        check("rst.ready", 64'(bus.ready), 64'd1);
        check("rst.done", 64'(bus.done), 64'd0);
        check("rst.p", 64'(bus.p_out), 64'd0);
        check("rst.iter", 64'(bus.iter_count), 64'd0);

        run_op("u13x11", 8'd13, 8'd11, 1'b0, 1'b0);
        run_op("u255x255", 8'd255, 8'd255, 1'b0, 1'b0);
        run_op("u200x0", 8'd200, 8'd0, 1'b0, 1'b0);
        run_op("s-128x-128", 8'h80, 8'h80, 1'b1, 1'b0);
        run_op("s-3x5", 8'hFD, 8'd5, 1'b1, 1'b0);
        run_op("s7x-1", 8'd7, 8'hFF, 1'b1, 1'b0);
        run_op("s0x-5", 8'd0, 8'hFB, 1'b1, 1'b0);
        run_op("poke", 8'd13, 8'd11, 1'b0, 1'b1);

        // clr mid-RUN discards the op and suppresses done.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a_in  = 8'd100;
        bus.b_in  = 8'd200;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr.ready", 64'(bus.ready), 64'd1);
        check("clr.p", 64'(bus.p_out), 64'd0);
        check("clr.done", 64'(bus.done), 64'd0);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("clr.nodone", 64'(pulses), 64'd0);
        run_op("afterclr", 8'd9, 8'd6, 1'b0, 1'b0);

        // start held high: back-to-back ops at period k+3 (k = 2 for b = 3).
        @(negedge clk);
        bus.start       = 1'b1;
        bus.a_in        = 8'd5;
        bus.b_in        = 8'd3;
        bus.signed_mode = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("hold.first", 64'(bus.done), 64'd1);
        check("hold.p", 64'(bus.p_out), 64'd15);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!bus.done && gap < 20);
        bus.start = 1'b0;
        check("hold.period", 64'(gap), 64'd5);
        @(negedge clk);

        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            bit           rs;
            ra = W'($urandom);
            rb = (i % 10 == 0) ? W'(0) : W'($urandom);
            rs = 1'($urandom);
            run_op("rand", ra, rb, rs, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
